cake_spawn_rng: RTL and testbench

- Pseudo-random spawn source for falling cakes. Sits directly upstream of the colour-select stage.
- Runs a 16-bit Galois LFSR and a spawn-interval timer.
- On each spawn event it draws a 3-bit colour index (rand_num) and an on-screen x position, then holds them behind a valid/ready handshake.
- rand_num drives the colour-select stage; x_pos drives the cake object controller.

---
 rtl/cake_pkg.sv | 21 ++
 rtl/lfsr16_galois.sv | 26 ++
 rtl/cake_spawn_rng.sv | 130 +++++++++++++
 tb/tb_cake_spawn_rng.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cake_pkg.sv
// Shared constants, state encoding and LFSR step function for the cake game blocks.
package cake_pkg;

    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam int          SCREEN_W     = 160;
    localparam int          SCREEN_H     = 120;
    localparam int          COLOR_W      = 3;

    // Spawn FSM encoding, kept as plain constants so older blocks can share it.
    typedef logic [1:0] state_t;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DRAW = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    // One right-shift Galois step; the mask is applied when the bit shifted out is 1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] value);
        return (value >> 1) ^ (value[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/lfsr16_galois.sv
// 16-bit Galois LFSR with synchronous load; reusable by any randomised block.
module lfsr16_galois
    import cake_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] state
);

    // Load beats stepping so a new seed lands even while the generator is frozen.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= SEED;
        end else if (load) begin
            state <= load_val;
        end else if (enable) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/cake_spawn_rng.sv
// Spawn source for falling cakes: timer/manual events trigger a draw of colour and
// column from the LFSR, and the result is held behind a valid/ready handshake.
module cake_spawn_rng
    import cake_pkg::*;
#(
    parameter logic [15:0] SEED         = DEFAULT_SEED,
    parameter int          SPAWN_PERIOD = 25,
    parameter int          X_MAX        = SCREEN_W - 1,
    parameter int          MAX_TRIES    = 3
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               enable,
    input  logic               seed_load,
    input  logic [15:0]        seed_in,
    input  logic               spawn_req,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [COLOR_W-1:0] rand_num,
    output logic [7:0]         x_pos,
    output logic               busy
);

    localparam int                  TIMER_W      = $clog2(SPAWN_PERIOD);
    localparam logic [TIMER_W-1:0]  TIMER_RELOAD = TIMER_W'(SPAWN_PERIOD - 1);
    localparam int                  TRY_W        = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0]    LAST_TRY     = TRY_W'(MAX_TRIES - 1);
    localparam logic [7:0]          X_LIMIT      = 8'(X_MAX);
    localparam logic [7:0]          X_WRAP       = 8'(X_MAX + 1);

    logic [15:0]        lfsr;
    logic [15:0]        seed_val;
    logic [TIMER_W-1:0] timer;
    logic [TRY_W-1:0]   try_cnt;
    state_t             state;
    logic               pending;
    logic               timer_hit;
    logic               spawn_event;
    logic               idle_start;
    logic [7:0]         cand;
    logic               cand_ok;
    logic               draw_done;
    logic               unused_lfsr_bits;

    // A zero seed would lock the LFSR, so it is replaced by the default seed.
    assign seed_val = (seed_in == 16'h0000) ? SEED : seed_in;

    lfsr16_galois #(.SEED(SEED)) u_lfsr (
        .clock    (clock),
        .resetn   (resetn),
        .enable   (enable),
        .load     (seed_load),
        .load_val (seed_val),
        .state    (lfsr)
    );

    assign timer_hit        = enable && (timer == '0);
    assign spawn_event      = spawn_req || timer_hit;
    assign idle_start       = (state == IDLE) && (spawn_event || pending);
    assign cand             = lfsr[15:8];
    assign cand_ok          = (cand <= X_LIMIT);
    assign draw_done        = (state == DRAW) && (cand_ok || (try_cnt == LAST_TRY));
    assign busy             = (state == DRAW) || (state == HOLD);
    assign unused_lfsr_bits = ^lfsr[7:3];

    // Spawn interval countdown; restarts on expiry and whenever a fresh draw begins from idle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            timer <= TIMER_RELOAD;
        end else if (idle_start || timer_hit) begin
            timer <= TIMER_RELOAD;
        end else if (enable) begin
            timer <= timer - 1'b1;
        end
    end

    // Spawn FSM: draw with bounded retries, then hold the result until the consumer takes it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            pending   <= 1'b0;
            try_cnt   <= '0;
            out_valid <= 1'b0;
            rand_num  <= '0;
            x_pos     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (spawn_event || pending) begin
                        state   <= DRAW;
                        pending <= 1'b0;
                        try_cnt <= '0;
                    end
                end
                DRAW: begin
                    if (spawn_event) begin
                        pending <= 1'b1;
                    end
                    if (draw_done) begin
                        rand_num  <= lfsr[COLOR_W-1:0];
                        x_pos     <= cand_ok ? cand : (cand - X_WRAP);
                        out_valid <= 1'b1;
                        try_cnt   <= '0;
                        state     <= HOLD;
                    end else begin
                        try_cnt <= try_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        if (pending) begin
                            state   <= DRAW;
                            pending <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            pending <= spawn_event;
                        end
                    end else if (spawn_event) begin
                        pending <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cake_spawn_rng.sv
// Self-checking bench for cake_spawn_rng: scoreboard of predicted draws from an
// independent LFSR model, one task per scenario.
module tb_cake_spawn_rng;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed_in = 16'h0000;
    logic        spawn_req = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [2:0]  rand_num;
    logic [7:0]  x_pos;
    logic        busy;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [2:0] r;
        logic [7:0] x;
        int         lat;
    } draw_t;

    draw_t sb[$];

    cake_spawn_rng dut (
        .clock     (clock),
        .resetn    (resetn),
        .enable    (enable),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .spawn_req (spawn_req),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .rand_num  (rand_num),
        .x_pos     (x_pos),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] model_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] lfsr_after(input logic [15:0] s, input int n);
        logic [15:0] v;
        v = s;
        for (int i = 0; i < n; i++) v = model_step(v);
        return v;
    endfunction

    // Expected draw when the first evaluation sees the seed advanced n steps.
    function automatic draw_t predict(input logic [15:0] s, input int n, input bit stepping);
        draw_t       d;
        logic [15:0] v;
        logic [7:0]  c;
        d.r = 3'd0;
        d.x = 8'd0;
        d.lat = 0;
        for (int t = 0; t < 3; t++) begin
            v = lfsr_after(s, stepping ? n + t : n);
            c = v[15:8];
            if (d.lat == 0 && (c <= 8'd159 || t == 2)) begin
                d.r = v[2:0];
                d.x = (c <= 8'd159) ? c : c - 8'd160;
                d.lat = t + 1;
            end
        end
        return d;
    endfunction

    task automatic do_reset(input logic en, input logic rdy);
        @(negedge clock);
        resetn = 1'b0;
        enable = 1'b0;
        seed_load = 1'b0;
        seed_in = 16'h0000;
        spawn_req = 1'b0;
        out_ready = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        enable = en;
        out_ready = rdy;
    endtask

    task automatic wait_valid(input int limit, output int cycles);
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < limit) begin
            @(negedge clock);
            cycles++;
        end
    endtask

    task automatic test_reset();
        draw_t exp;
        int    cyc;
        do_reset(1'b1, 1'b0);
        total++; if (dut.lfsr !== 16'hACE1) begin bad++; $display("[TB] FAIL reset_lfsr got=%h exp=%h", dut.lfsr, 16'hACE1); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        total++; if (rand_num !== 3'd0 || x_pos !== 8'd0) begin bad++; $display("[TB] FAIL reset_data got=%h/%h exp=0/0", rand_num, x_pos); end
        @(negedge clock);
        total++; if (dut.lfsr !== 16'hE270) begin bad++; $display("[TB] FAIL lfsr_step1 got=%h exp=%h", dut.lfsr, 16'hE270); end
        @(negedge clock);
        total++; if (dut.lfsr !== 16'h7138) begin bad++; $display("[TB] FAIL lfsr_step2 got=%h exp=%h", dut.lfsr, 16'h7138); end
        repeat (22) @(negedge clock);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL timer_early got=%b exp=0", busy); end
        sb.push_back(predict(16'hACE1, 25, 1'b1));
        @(negedge clock);
        total++; if (busy !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL timer_event busy/valid got=%b/%b exp=1/0", busy, out_valid); end
        wait_valid(4, cyc);
        exp = sb.pop_front();
        total++; if (cyc !== exp.lat) begin bad++; $display("[TB] FAIL timer_latency got=%0d exp=%0d", cyc, exp.lat); end
        total++; if (rand_num !== exp.r || x_pos !== exp.x) begin bad++; $display("[TB] FAIL timer_draw got=%h/%0d exp=%h/%0d", rand_num, x_pos, exp.r, exp.x); end
    endtask

    task automatic test_seed_one();
        draw_t exp;
        int    cyc;
        do_reset(1'b0, 1'b1);
        seed_load = 1'b1;
        seed_in = 16'h0001;
        @(negedge clock);
        total++; if (dut.lfsr !== 16'h0001) begin bad++; $display("[TB] FAIL seed_one_load got=%h exp=0001", dut.lfsr); end
        seed_load = 1'b0;
        spawn_req = 1'b1;
        sb.push_back(predict(16'h0001, 0, 1'b0));
        @(negedge clock);
        spawn_req = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL seed_one_busy got=%b exp=1", busy); end
        wait_valid(5, cyc);
        exp = sb.pop_front();
        total++; if (cyc !== exp.lat) begin bad++; $display("[TB] FAIL seed_one_latency got=%0d exp=%0d", cyc, exp.lat); end
        total++; if (rand_num !== exp.r || x_pos !== exp.x) begin bad++; $display("[TB] FAIL seed_one_draw got=%h/%0d exp=%h/%0d", rand_num, x_pos, exp.r, exp.x); end
        @(negedge clock);
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL seed_one_handshake valid/busy got=%b/%b exp=0/0", out_valid, busy); end
    endtask

    task automatic test_seed_retry();
        draw_t exp;
        int    cyc;
        do_reset(1'b0, 1'b0);
        seed_load = 1'b1;
        seed_in = 16'hA5F3;
        @(negedge clock);
        seed_load = 1'b0;
        spawn_req = 1'b1;
        sb.push_back(predict(16'hA5F3, 0, 1'b0));
        @(negedge clock);
        spawn_req = 1'b0;
        wait_valid(6, cyc);
        exp = sb.pop_front();
        total++; if (cyc !== exp.lat) begin bad++; $display("[TB] FAIL retry_latency got=%0d exp=%0d", cyc, exp.lat); end
        total++; if (rand_num !== exp.r || x_pos !== exp.x) begin bad++; $display("[TB] FAIL retry_draw got=%h/%0d exp=%h/%0d", rand_num, x_pos, exp.r, exp.x); end
        seed_load = 1'b1;
        seed_in = 16'h0001;
        @(negedge clock);
        seed_load = 1'b0;
        repeat (3) @(negedge clock);
        total++; if (dut.lfsr !== 16'h0001) begin bad++; $display("[TB] FAIL hold_seed_lfsr got=%h exp=0001", dut.lfsr); end
        total++; if (out_valid !== 1'b1 || rand_num !== exp.r || x_pos !== exp.x) begin bad++; $display("[TB] FAIL hold_stable got=%b/%h/%0d exp=1/%h/%0d", out_valid, rand_num, x_pos, exp.r, exp.x); end
        out_ready = 1'b1;
        @(negedge clock);
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL retry_release valid/busy got=%b/%b exp=0/0", out_valid, busy); end
    endtask

    task automatic test_seed_zero();
        do_reset(1'b1, 1'b0);
        repeat (3) @(negedge clock);
        seed_load = 1'b1;
        seed_in = 16'h0000;
        @(negedge clock);
        total++; if (dut.lfsr !== 16'hACE1) begin bad++; $display("[TB] FAIL seed_zero got=%h exp=ACE1", dut.lfsr); end
        seed_in = 16'h1234;
        @(negedge clock);
        total++; if (dut.lfsr !== 16'h1234) begin bad++; $display("[TB] FAIL seed_priority got=%h exp=1234", dut.lfsr); end
        seed_load = 1'b0;
        @(negedge clock);
        total++; if (dut.lfsr !== model_step(16'h1234)) begin bad++; $display("[TB] FAIL seed_then_step got=%h exp=%h", dut.lfsr, model_step(16'h1234)); end
    endtask

    task automatic test_back_to_back();
        draw_t exp;
        int    cyc;
        int    edge_no;
        int    rises;
        bit    held_ok;
        logic  prev;
        do_reset(1'b1, 1'b0);
        sb.push_back(predict(16'hACE1, 25, 1'b1));
        repeat (25) @(negedge clock);
        wait_valid(4, cyc);
        exp = sb.pop_front();
        total++; if (rand_num !== exp.r || x_pos !== exp.x) begin bad++; $display("[TB] FAIL bp_first_draw got=%h/%0d exp=%h/%0d", rand_num, x_pos, exp.r, exp.x); end
        edge_no = 25 + cyc;
        held_ok = 1'b1;
        while (edge_no < 80) begin
            @(negedge clock);
            edge_no++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || rand_num !== exp.r || x_pos !== exp.x) held_ok = 1'b0;
        end
        total++; if (held_ok !== 1'b1) begin bad++; $display("[TB] FAIL bp_hold_stable got=%b exp=1", held_ok); end
        sb.push_back(predict(16'hACE1, 81, 1'b1));
        out_ready = 1'b1;
        @(negedge clock);
        total++; if (out_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("[TB] FAIL bp_pending_redraw valid/busy got=%b/%b exp=0/1", out_valid, busy); end
        rises = 0;
        prev = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            if (out_valid === 1'b1 && prev !== 1'b1) begin
                rises++;
                if (rises == 1) begin
                    exp = sb.pop_front();
                    total++; if (i + 1 !== exp.lat || rand_num !== exp.r || x_pos !== exp.x) begin bad++; $display("[TB] FAIL bp_second_draw got=%0d/%h/%0d exp=%0d/%h/%0d", i + 1, rand_num, x_pos, exp.lat, exp.r, exp.x); end
                end
            end
            prev = out_valid;
        end
        total++; if (rises !== 1) begin bad++; $display("[TB] FAIL bp_draw_count got=%0d exp=1", rises); end
        total++; if (sb.size() !== 0) begin bad++; $display("[TB] FAIL bp_scoreboard_left got=%0d exp=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit idle_ok;
        do_reset(1'b0, 1'b0);
        seed_load = 1'b1;
        seed_in = 16'hA5F3;
        @(negedge clock);
        seed_load = 1'b0;
        spawn_req = 1'b1;
        @(negedge clock);
        spawn_req = 1'b0;
        @(negedge clock);
        total++; if (busy !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_draw_state busy/valid got=%b/%b exp=1/0", busy, out_valid); end
        #2 resetn = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || out_valid !== 1'b0 || dut.lfsr !== 16'hACE1) begin bad++; $display("[TB] FAIL reset_in_draw got=%b/%b/%h exp=0/0/ACE1", busy, out_valid, dut.lfsr); end
        @(negedge clock);
        resetn = 1'b1;
        seed_load = 1'b1;
        seed_in = 16'hA5F3;
        @(negedge clock);
        seed_load = 1'b0;
        spawn_req = 1'b1;
        @(negedge clock);
        spawn_req = 1'b0;
        wait_valid(6, cyc);
        total++; if (out_valid !== 1'b1 || x_pos !== 8'd5 || rand_num !== 3'b011) begin bad++; $display("[TB] FAIL pre_reset_hold got=%b/%0d/%h exp=1/5/3", out_valid, x_pos, rand_num); end
        spawn_req = 1'b1;
        @(negedge clock);
        spawn_req = 1'b0;
        #2 resetn = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0 || rand_num !== 3'd0 || x_pos !== 8'd0) begin bad++; $display("[TB] FAIL reset_in_hold got=%b/%b/%h/%0d exp=0/0/0/0", out_valid, busy, rand_num, x_pos); end
        total++; if (dut.lfsr !== 16'hACE1) begin bad++; $display("[TB] FAIL reset_in_hold_lfsr got=%h exp=ACE1", dut.lfsr); end
        @(negedge clock);
        resetn = 1'b1;
        idle_ok = 1'b1;
        repeat (5) begin
            @(negedge clock);
            if (busy !== 1'b0 || out_valid !== 1'b0) idle_ok = 1'b0;
        end
        total++; if (idle_ok !== 1'b1) begin bad++; $display("[TB] FAIL pending_lost got=%b exp=1", idle_ok); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting cake_spawn_rng bench");
        test_reset();
        test_seed_one();
        test_seed_retry();
        test_seed_zero();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
